// File: rtl/spi_master_arb.sv
// SPI mode-0 master shared by NUM_REQ requesters under round-robin arbitration.
// Each grant runs one fixed-length DATA_W-bit frame; all outputs are registered.
module spi_master_arb #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      SCLK,
    output logic                      CS_n,
    output logic                      MOSI,
    input  logic                      MISO
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    r_owner;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [DATA_W-1:0]   r_rx_sr;
    logic [DATA_W-1:0]   r_rx_data;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_busy;
    logic                r_sclk;
    logic                r_cs_n;

    logic [IDX_W-1:0]    w_winner;
    logic                w_found;
    logic                w_any_req;
    logic                w_div_end;
    logic                w_last_bit;
    logic [DATA_W-1:0]   w_tx_word;

    assign w_any_req  = |req;
    assign w_div_end  = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_W));
    assign w_tx_word  = tx_data[w_winner*DATA_W +: DATA_W];

    // MOSI is the MSB of the transmit shift register, so it is cleared with it.
    assign gnt     = r_gnt;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign SCLK    = r_sclk;
    assign CS_n    = r_cs_n;
    assign MOSI    = r_tx_sr[DATA_W-1];

    // Round-robin pick: first requester above the last winner, wrapping to itself.
    always_comb begin
        w_winner = r_last;
        w_found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req[(int'(r_last) + k) % NUM_REQ]) begin
                w_winner = IDX_W'((int'(r_last) + k) % NUM_REQ);
                w_found  = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Frame sequencing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; SHIFT ends only after the last low phase completes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_next_state = S_SETUP;
                else           w_next_state = S_IDLE;
            end
            S_SETUP: begin
                if (w_div_end) w_next_state = S_SHIFT;
                else           w_next_state = S_SETUP;
            end
            S_SHIFT: begin
                if (w_div_end && !r_sclk && w_last_bit) w_next_state = S_HOLD;
                else                                    w_next_state = S_SHIFT;
            end
            S_HOLD: begin
                if (w_div_end) w_next_state = S_GAP;
                else           w_next_state = S_HOLD;
            end
            S_GAP: begin
                if (w_div_end) w_next_state = S_IDLE;
                else           w_next_state = S_GAP;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, advanced once per divided half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_owner   <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    r_div_cnt <= '0;
                    if (w_any_req) begin
                        r_gnt     <= ONE_HOT0 << w_winner;
                        r_busy    <= 1'b1;
                        r_cs_n    <= 1'b0;
                        r_tx_sr   <= w_tx_word;
                        r_owner   <= w_winner;
                        r_last    <= w_winner;
                        r_bit_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b1;
                        r_rx_sr   <= {r_rx_sr[DATA_W-2:0], MISO};
                        r_bit_cnt <= CNT_W'(1);
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        if (r_sclk) begin
                            // Falling edge: present the next bit, except after the final one.
                            r_sclk <= 1'b0;
                            if (!w_last_bit) begin
                                r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                            end
                        end else if (!w_last_bit) begin
                            r_sclk    <= 1'b1;
                            r_rx_sr   <= {r_rx_sr[DATA_W-2:0], MISO};
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_cs_n    <= 1'b1;
                        r_tx_sr   <= '0;
                        r_rx_data <= r_rx_sr;
                        r_done    <= ONE_HOT0 << r_owner;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_div_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
- SPI mode-0 master that shares one 16-bit SPI slave link between NUM_REQ local requesters.
- Round-robin arbitration; one full-word transfer per grant.
- Generates SCLK/CS_n/MOSI from the system clock, samples MISO and returns the received word to the granted requester.
- Sits between the requester logic and the off-block SPI slave port (16-bit shift register, captures on SCLK rising edge).

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- DATA_W, 16, bits per transfer (fixed frame length, MSB first).
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transfer request, level.
- tx_data  in  NUM_REQ*DATA_W  word for requester i at [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted, tx_data captured.
- done  out  NUM_REQ  one-hot, 1-cycle pulse to the owner when its transfer completes.
- rx_data  out  DATA_W  word received on MISO, valid from done onward.
- busy  out  1  high from grant until return to IDLE.
- SCLK  out  1  SPI clock, idle low (CPOL=0).
- CS_n  out  1  chip select, active low.
- MOSI  out  1  serial data out, MSB first.
- MISO  in  1  serial data in, sampled on SCLK rising edge.

Behaviour:
- Reset values: SCLK=0, CS_n=1, MOSI=0, gnt=0, done=0, rx_data=0, busy=0. RR pointer set so req[0] has top priority. FSM=IDLE.
- All outputs are registered; no combinational path from req or MISO to any output.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE, any req high:
  - Winner = first set req at index > last winner, wrapping.
  - Next cycle: gnt[winner]=1 for exactly 1 cycle, busy=1, CS_n=0, MOSI=tx_data[winner][DATA_W-1], shift reg loaded. Enter SETUP.
- SETUP: CLK_DIV cycles with SCLK low (CS-to-first-edge setup).
- SHIFT: DATA_W SCLK periods, each = CLK_DIV cycles high then CLK_DIV cycles low.
  - On each SCLK rising edge: shift MISO into rx shift reg LSB.
  - On each falling edge except the last: MOSI <- next bit.
  - A bit counter counts rising edges; after the DATA_W-th low phase, enter HOLD.
- HOLD: CLK_DIV cycles, SCLK low, CS_n low.
- HOLD exit:
  - CS_n=1, rx_data <- rx shift reg, done[owner]=1 for 1 cycle, MOSI=0. Enter GAP.
  - Total CS_n low = (2*DATA_W+2)*CLK_DIV cycles.
- GAP: CLK_DIV cycles with CS_n high, then IDLE with busy=0. Minimum CS_n high between frames = CLK_DIV+1 cycles.
- Requester rules:
  - Hold req and tx_data stable until gnt.
  - Dropping req before gnt withdraws the request; no gnt, no done.
  - req may stay high after gnt to queue another transfer; it is re-arbitrated in IDLE.
  - req changes during a transfer are ignored until IDLE.
- Simultaneous requests: exactly one grant per IDLE evaluation; RR pointer moves to the winner, so two continuously requesting ports strictly alternate.
- rx_data holds its value until the next done; it is not cleared between frames.
- Reset mid-transfer (any state):
  - Next cycle all outputs take reset values and FSM=IDLE.
  - No done pulse; the partial frame is abandoned.
  - The slave's bit counter is left misaligned; slave reset is the system's responsibility.
- CLK_DIV=1: SCLK period 2 clk cycles; the state sequence is unchanged.

Test Plan:
- Single transfer, CLK_DIV=4, req[0]=1, tx_data[0]=0xA5C3, MISO looped to MOSI -> gnt[0] 1 cycle, CS_n low for exactly 136 cycles, 16 SCLK rising edges, MOSI bits A5C3 MSB first, then done[0] pulse and rx_data=0xA5C3.
- MISO driven by a model slave returning 0x1234 -> rx_data=0x1234 at done; MOSI stable across every SCLK rising edge (changes only on falling edges or at CS_n assertion).
- req[0] and req[1] asserted together after reset and held -> grant order 0,1,0,1; CS_n high >= 5 cycles between frames; done matches the owner each frame.
- Reset asserted during SHIFT after the 7th rising edge -> following cycle CS_n=1, SCLK=0, MOSI=0, busy=0, no done; a new req[1] transfer afterwards completes normally.
- CLK_DIV=1, tx_data=0xFFFF then 0x0000 back to back -> 34-cycle CS_n-low frames, SCLK period 2 cycles, correct loopback words.
- req[1] pulsed for 1 cycle while a req[0] transfer is in progress -> no gnt[1], no done[1].
